// File: rtl/global_pkg.sv
// Shared state encoding for the UART command-frame parser.
package global_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_CMD     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_END     = 3'd4
    } PARSE_STATE_e;

endpackage

// File: rtl/uart_pkg.sv
// UART framing constants and the error codes reported by the command parser.
package uart_pkg;

    localparam logic [7:0] START_CMD = 8'hFE;
    localparam logic [7:0] END_CMD   = 8'hEF;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_CMD = 2'd1,
        ERR_NO_END  = 2'd2,
        ERR_TIMEOUT = 2'd3
    } PARSE_ERR_e;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-in / command-out bundle of the UART command parser.
// The parser sits on the slave side; the UART plus command datapath is the master.
interface uart_cmd_parser_if
    import uart_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_CMD = 5
);
    logic [DATA_W-1:0]  uart_data;
    logic               rx_interrupt;
    logic               clear_interrupt;
    logic [NUM_CMD-1:0] push;
    logic [DATA_W-1:0]  push_data;
    logic [NUM_CMD-1:0] cmd_id;
    logic               busy;
    logic               frame_done;
    logic               frame_err;
    PARSE_ERR_e         err_code;

    modport slave (
        input  uart_data, rx_interrupt,
        output clear_interrupt, push, push_data, cmd_id,
               busy, frame_done, frame_err, err_code
    );

    modport master (
        output uart_data, rx_interrupt,
        input  clear_interrupt, push, push_data, cmd_id,
               busy, frame_done, frame_err, err_code
    );
endinterface

// File: rtl/timeout_counter.sv
// Inter-byte idle counter. Clears on clr, counts while en, and raises a
// single-cycle expire in the cycle whose clock edge takes the count to LIMIT-1.
// A clear in the same cycle suppresses the expiry. LIMIT below 2 disables it.
module timeout_counter #(
    parameter int LIMIT = 100000,
    parameter int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    logic [CNT_W-1:0] cnt;

    // Count idle cycles, saturating at LIMIT-1 so the counter never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_W'(LIMIT - 1))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire = (LIMIT >= 2) && en && !clr && (cnt == CNT_W'(LIMIT - 2));
endmodule

// File: rtl/uart_cmd_parser.sv
// UART command-frame parser: START, LEN, CMD, LEN payload bytes, END.
// Payload bytes are strobed onto the one-hot channel of the active command;
// every frame ends in a frame_done or a frame_err pulse with an error code.
module uart_cmd_parser
    import uart_pkg::*;
    import global_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int NUM_CMD     = 5,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    uart_cmd_parser_if.slave  bus
);
    PARSE_STATE_e       state;
    logic               busy_r;
    logic               clr_r;
    logic [NUM_CMD-1:0] push_r;
    logic [DATA_W-1:0]  push_data_r;
    logic [NUM_CMD-1:0] cmd_id_r;
    logic               done_r;
    logic               err_r;
    PARSE_ERR_e         err_code_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   cnt_r;
    logic [LEN_W:0]     cnt_inc;
    logic               accept;
    logic               tmo_expire;

    // A byte is taken only when the previous one has already been acknowledged.
    assign accept  = bus.rx_interrupt && !clr_r;
    assign cnt_inc = {1'b0, cnt_r} + {{LEN_W{1'b0}}, 1'b1};

    function automatic logic cmd_ok(input logic [DATA_W-1:0] code);
        return (code != '0) && (int'(code) <= NUM_CMD);
    endfunction

    function automatic logic [NUM_CMD-1:0] cmd_onehot(input logic [DATA_W-1:0] code);
        return NUM_CMD'(1) << (code - DATA_W'(1));
    endfunction

    timeout_counter #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (busy_r),
        .expire (tmo_expire)
    );

    // Frame FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy_r      <= 1'b0;
            clr_r       <= 1'b0;
            push_r      <= '0;
            push_data_r <= '0;
            cmd_id_r    <= '0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            err_code_r  <= ERR_NONE;
            len_r       <= '0;
            cnt_r       <= '0;
        end else begin
            clr_r  <= accept;
            push_r <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            if (accept) begin
                unique case (state)
                    ST_IDLE: begin
                        // Non-START bytes are acknowledged and dropped.
                        if (bus.uart_data == DATA_W'(START_CMD)) begin
                            state      <= ST_LEN;
                            busy_r     <= 1'b1;
                            err_code_r <= ERR_NONE;
                            cmd_id_r   <= '0;
                            cnt_r      <= '0;
                        end
                    end
                    ST_LEN: begin
                        len_r <= LEN_W'(bus.uart_data);
                        state <= ST_CMD;
                    end
                    ST_CMD: begin
                        if (cmd_ok(bus.uart_data)) begin
                            cmd_id_r <= cmd_onehot(bus.uart_data);
                            state    <= (len_r == '0) ? ST_END : ST_PAYLOAD;
                        end else begin
                            err_r      <= 1'b1;
                            err_code_r <= ERR_BAD_CMD;
                            state      <= ST_IDLE;
                            busy_r     <= 1'b0;
                        end
                    end
                    ST_PAYLOAD: begin
                        // START/END values are plain data here.
                        push_r      <= cmd_id_r;
                        push_data_r <= bus.uart_data;
                        cnt_r       <= cnt_inc[LEN_W-1:0];
                        if (cnt_inc == {1'b0, len_r}) begin
                            state <= ST_END;
                        end
                    end
                    ST_END: begin
                        // A wrong END byte is consumed here, never reused as START.
                        state  <= ST_IDLE;
                        busy_r <= 1'b0;
                        if (bus.uart_data == DATA_W'(END_CMD)) begin
                            done_r <= 1'b1;
                        end else begin
                            err_r      <= 1'b1;
                            err_code_r <= ERR_NO_END;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end else if (tmo_expire) begin
                err_r      <= 1'b1;
                err_code_r <= ERR_TIMEOUT;
                state      <= ST_IDLE;
                busy_r     <= 1'b0;
            end
        end
    end

    assign bus.clear_interrupt = clr_r;
    assign bus.push            = push_r;
    assign bus.push_data       = push_data_r;
    assign bus.cmd_id          = cmd_id_r;
    assign bus.busy            = busy_r;
    assign bus.frame_done      = done_r;
    assign bus.frame_err       = err_r;
    assign bus.err_code        = err_code_r;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: directed frames plus random frames scored
// against a byte-stream frame model.
module tb_uart_cmd_parser;
    import uart_pkg::*;

    localparam int DATA_W  = 8;
    localparam int NUM_CMD = 5;
    localparam int TMO     = 16;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    int push_log[$];
    int evt_log[$];
    int exp_push[$];
    int exp_evt[$];
    int exp_cmd;

    uart_cmd_parser_if #(.DATA_W(DATA_W), .NUM_CMD(NUM_CMD)) bus ();

    uart_cmd_parser #(
        .DATA_W      (DATA_W),
        .NUM_CMD     (NUM_CMD),
        .LEN_W       (8),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Record every push (channel<<8 | data) and every frame end (7 = done, else err_code).
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.push != '0) push_log.push_back(int'({bus.push, bus.push_data}));
            if (bus.frame_done) evt_log.push_back(7);
            if (bus.frame_err)  evt_log.push_back(int'(bus.err_code));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one byte and hold it until the DUT takes it; returns #1 after the accept edge.
    task automatic send_byte(input logic [7:0] b);
        logic pre;
        int   guard;
        guard = 0;
        bus.uart_data    = b;
        bus.rx_interrupt = 1'b1;
        do begin
            pre = bus.clear_interrupt;
            @(posedge clk);
            #1;
            guard++;
        end while (pre && guard < 8);
        check("ack", {31'd0, bus.clear_interrupt}, 32'd1);
        bus.rx_interrupt = 1'b0;
    endtask

    task automatic send_seq(input bq_t b);
        foreach (b[i]) send_byte(b[i]);
    endtask

    task automatic clear_logs();
        push_log.delete();
        evt_log.delete();
    endtask

    // Frame model: walks the byte stream the way the framing rules read it.
    function automatic void model_stream(input bq_t b);
        int i;
        int n;
        int len;
        int c;
        i = 0;
        n = b.size();
        exp_push.delete();
        exp_evt.delete();
        while (i < n) begin
            if (b[i] != START_CMD) begin
                i++;
                continue;
            end
            exp_cmd = 0;
            if (i + 2 >= n) return;
            len = int'(b[i+1]);
            c   = int'(b[i+2]);
            i  += 3;
            if (c < 1 || c > NUM_CMD) begin
                exp_evt.push_back(1);
                continue;
            end
            exp_cmd = 1 << (c - 1);
            for (int k = 0; k < len && i < n; k++) begin
                exp_push.push_back((exp_cmd << 8) | int'(b[i]));
                i++;
            end
            if (i >= n) return;
            exp_evt.push_back((b[i] == END_CMD) ? 7 : 2);
            i++;
        end
    endfunction

    task automatic compare_logs(input string tag);
        int e;
        check({tag, "_npush"}, push_log.size(), exp_push.size());
        for (int k = 0; k < push_log.size() && k < exp_push.size(); k++)
            check({tag, "_push"}, push_log[k], exp_push[k]);
        check({tag, "_nevt"}, evt_log.size(), exp_evt.size());
        for (int k = 0; k < evt_log.size() && k < exp_evt.size(); k++)
            check({tag, "_evt"}, evt_log[k], exp_evt[k]);
        check({tag, "_cmd_id"}, bus.cmd_id, exp_cmd);
        e = (exp_evt.size() == 0) ? 0 : exp_evt[exp_evt.size()-1];
        check({tag, "_err_code"}, bus.err_code, (e == 7) ? 0 : e);
        check({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        bq_t fr;
        int  k_err;
        int  len;
        int  c;

        bus.uart_data    = '0;
        bus.rx_interrupt = 1'b0;
        #1;
        check("rst_push",      bus.push, 0);
        check("rst_push_data", bus.push_data, 0);
        check("rst_cmd_id",    bus.cmd_id, 0);
        check("rst_err_code",  bus.err_code, 0);
        check("rst_busy",      bus.busy, 0);
        check("rst_clr",       bus.clear_interrupt, 0);
        check("rst_done",      bus.frame_done, 0);
        check("rst_err",       bus.frame_err, 0);
        tick(3);
        rst = 1'b0;
        tick(2);

        // Three-byte payload on command 2.
        clear_logs();
        send_byte(8'hFE);
        check("f1_busy", bus.busy, 1);
        send_byte(8'h03);
        send_byte(8'h02);
        check("f1_cmd_id", bus.cmd_id, 5'b00010);
        send_byte(8'hAA);
        check("f1_push0", {bus.push, bus.push_data}, {5'b00010, 8'hAA});
        tick(1);
        check("f1_push_gap", bus.push, 0);
        send_byte(8'hBB);
        check("f1_push1", {bus.push, bus.push_data}, {5'b00010, 8'hBB});
        send_byte(8'hCC);
        check("f1_push2", {bus.push, bus.push_data}, {5'b00010, 8'hCC});
        send_byte(8'hEF);
        check("f1_done", bus.frame_done, 1);
        check("f1_err_code", bus.err_code, 0);
        tick(1);
        check("f1_done_pulse", bus.frame_done, 0);
        check("f1_npush", push_log.size(), 3);
        check("f1_nevt", evt_log.size(), 1);

        // Empty payload on command 5.
        clear_logs();
        send_byte(8'hFE);
        send_byte(8'h00);
        send_byte(8'h05);
        check("f2_cmd_id", bus.cmd_id, 5'b10000);
        send_byte(8'hEF);
        check("f2_done", bus.frame_done, 1);
        tick(2);
        check("f2_npush", push_log.size(), 0);
        check("f2_nevt", evt_log.size(), 1);

        // Bad command, then a fresh START must be taken.
        send_byte(8'hFE);
        send_byte(8'h01);
        send_byte(8'h07);
        check("f3_err", bus.frame_err, 1);
        check("f3_err_code", bus.err_code, 1);
        check("f3_busy", bus.busy, 0);
        send_byte(8'hFE);
        check("f3_restart_busy", bus.busy, 1);
        check("f3_restart_err_code", bus.err_code, 0);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hEF);
        check("f3_restart_done", bus.frame_done, 1);

        // Missing END: the wrong byte is swallowed and the parser is idle.
        send_byte(8'hFE);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h55);
        check("f4_push", {bus.push, bus.push_data}, {5'b00001, 8'h55});
        send_byte(8'h33);
        check("f4_err", bus.frame_err, 1);
        check("f4_err_code", bus.err_code, 2);
        check("f4_busy", bus.busy, 0);

        // Stall mid-payload until the inter-byte timeout fires.
        send_byte(8'hFE);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h11);
        k_err = -1;
        for (int k = 1; k <= 30 && k_err < 0; k++) begin
            tick(1);
            if (bus.frame_err) k_err = k;
        end
        check("f5_tmo_cycles", k_err, TMO - 1);
        check("f5_err_code", bus.err_code, 3);
        check("f5_busy", bus.busy, 0);

        // START and END values inside the payload are data.
        clear_logs();
        send_byte(8'hFE);
        send_byte(8'h02);
        send_byte(8'h04);
        send_byte(8'hFE);
        check("f6_push0", {bus.push, bus.push_data}, {5'b01000, 8'hFE});
        send_byte(8'hEF);
        check("f6_push1", {bus.push, bus.push_data}, {5'b01000, 8'hEF});
        send_byte(8'hEF);
        check("f6_done", bus.frame_done, 1);

        // Asynchronous reset in the middle of a payload.
        send_byte(8'hFE);
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'hAA);
        rst = 1'b1;
        #1;
        check("r_push",      bus.push, 0);
        check("r_push_data", bus.push_data, 0);
        check("r_cmd_id",    bus.cmd_id, 0);
        check("r_busy",      bus.busy, 0);
        check("r_clr",       bus.clear_interrupt, 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        send_byte(8'hFE);
        send_byte(8'h01);
        send_byte(8'h03);
        send_byte(8'h77);
        check("r_push_after", {bus.push, bus.push_data}, {5'b00100, 8'h77});
        send_byte(8'hEF);
        check("r_done_after", bus.frame_done, 1);
        tick(2);

        // Random frames against the stream model.
        for (int f = 0; f < 16; f++) begin
            fr.delete();
            if ($urandom_range(0, 3) == 0) fr.push_back(8'(($urandom_range(0, 0) + 8'h10 + f)));
            fr.push_back(8'hFE);
            len = $urandom_range(0, 5);
            fr.push_back(8'(len));
            if ($urandom_range(0, 4) == 0) begin
                c = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(6, 200);
                fr.push_back(8'(c));
            end else begin
                c = $urandom_range(1, NUM_CMD);
                fr.push_back(8'(c));
                for (int k = 0; k < len; k++) begin
                    case ($urandom_range(0, 5))
                        0:       fr.push_back(8'hFE);
                        1:       fr.push_back(8'hEF);
                        default: fr.push_back(8'($urandom_range(0, 255)));
                    endcase
                end
                if ($urandom_range(0, 4) == 0) fr.push_back(8'($urandom_range(0, 8'hEE)));
                else                            fr.push_back(8'hEF);
            end
            model_stream(fr);
            clear_logs();
            foreach (fr[i]) begin
                send_byte(fr[i]);
                tick($urandom_range(0, 3));
            end
            tick(3);
            compare_logs($sformatf("rnd%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Parametrised UART command-frame parser between the UART receiver and the command datapath. Consumes bytes flagged by `rx_interrupt` and validates the frame structure START, LEN, CMD, LEN payload bytes, END. Payload bytes are routed to one of `NUM_CMD` one-hot push channels. Frames are checked for bad command codes, missing END markers and inter-byte timeouts, and each frame ends with a done or error pulse.

## Interface
Parameters:
- `DATA_W`, default 8: UART byte width.
- `NUM_CMD`, default 5: number of command channels; valid command codes are 1..`NUM_CMD`.
- `LEN_W`, default 8: width of the LEN field and the payload counter.
- `TIMEOUT_CYC`, default 100000: maximum idle cycles between bytes inside a frame; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `uart_data`, input, `DATA_W`: received byte; valid while `rx_interrupt` is high.
- `rx_interrupt`, input, 1: byte-available flag; held high by the UART until it is cleared.
- `clear_interrupt`, output, 1: one-cycle acknowledge for each consumed byte.
- `push`, output, `NUM_CMD`: one-hot payload strobe; bit k = command code k+1.
- `push_data`, output, `DATA_W`: payload byte; valid when any `push` bit is set.
- `cmd_id`, output, `NUM_CMD`: one-hot active command; held from CMD accept until the next START.
- `busy`, output, 1: high whenever the state is not IDLE.
- `frame_done`, output, 1: one-cycle pulse after a valid END is accepted.
- `frame_err`, output, 1: one-cycle pulse when a frame is aborted.
- `err_code`, output, 2: 0 = none, 1 = bad CMD, 2 = missing END, 3 = timeout. Held until the next START is accepted.

## Operation
- Byte accept condition: `rx_interrupt && !clear_interrupt`. Every accepted byte produces `clear_interrupt` = 1 in the next cycle, in every state.
- States: IDLE, LEN, CMD, PAYLOAD, END.
  - IDLE: START_CMD → LEN, and clears `err_code`, `cmd_id` and the counter. Any other byte is consumed and dropped.
  - LEN: byte is stored as `len`. → CMD.
  - CMD: code c in 1..`NUM_CMD`: `cmd_id` = 1<<(c−1). If `len` = 0 → END, else → PAYLOAD. Any other code: `frame_err`, `err_code` = 1, → IDLE.
  - PAYLOAD: each byte drives `push_data` = byte and `push` = `cmd_id` for one cycle, then increments the counter. When the counter reaches `len` → END.
  - END: END_CMD → `frame_done`, → IDLE. Any other byte: `frame_err`, `err_code` = 2, → IDLE; that byte is not re-examined as a START.
- START_CMD and END_CMD values appearing inside PAYLOAD are treated as data.
- Payload bytes already pushed are not retracted on error; consumers discard them on `frame_err`.
- Timeout:
  - The counter clears on every accepted byte and counts while not IDLE.
  - When it reaches `TIMEOUT_CYC`−1: `frame_err`, `err_code` = 3, → IDLE.
  - If a byte is accepted in the same cycle, the byte wins and the timeout does not fire.

## Timing
- Reset values: state = IDLE; all outputs 0, including `push`, `push_data`, `cmd_id`, `err_code`, `busy`, `clear_interrupt`, `frame_done`, `frame_err`.
- All outputs are registered. `push`, `push_data`, `frame_done`, `frame_err` and `clear_interrupt` appear exactly 1 cycle after the accept edge.
- Back-to-back bytes: at most one byte per 2 cycles, because of the acknowledge gap.
- Reset mid-frame: immediate return to IDLE; any pulse in flight is lost.
- Minimum frame length is 4 bytes (LEN = 0). The maximum payload is 2^`LEN_W`−1 bytes.

## Structure
- Constants go in `uart_pkg`: START_CMD = 8'hFE, END_CMD = 8'hEF, and the error-code enum `PARSE_ERR_e`.
- State enum `PARSE_STATE_e` goes in `global_pkg`.
- One sub-module, `timeout_counter`: parametrised counter with clear and enable inputs and an expiry pulse.

## Test plan
- Frame FE 03 02 AA BB CC EF → `push` = 5'b00010 three times with data AA, BB, CC; `frame_done` pulses once; `err_code` = 0.
- Frame FE 00 05 EF → no `push`; `cmd_id` = 5'b10000; `frame_done` pulses once.
- Frame FE 01 07 → `frame_err` with `err_code` = 1; the next FE is accepted as a new frame.
- Frame FE 01 01 55 33 → one push of 55 on `push`[0], then `frame_err` with `err_code` = 2. The parser must be in IDLE after the 33 byte.
- `TIMEOUT_CYC` = 16: send FE 02 03 11 then stall → `frame_err` with `err_code` = 3 exactly 15 cycles after the last accept, and `busy` = 0.
- Payload FE 02 04 FE EF EF → pushes FE and EF on `push`[3], then `frame_done`. Separately, assert `rst` mid-PAYLOAD → all outputs 0 and the following frame parses normally.
